// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: state encoding, default framing and the parity helper.
// Used by both the transmit and receive halves.
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam int DEF_CLKS_PER_BIT = 5208;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_PARITY_EN    = 1;
    localparam int DEF_PARITY_ODD   = 0;

    // Even parity is the XOR of the payload; odd parity is its complement.
    function automatic logic parity_of(input logic [31:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// Shared with the receive half.
module uart_tx_serializer_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a byte and sends start, data (LSB first), optional parity, stop.
// All outputs are registered so tx never glitches.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_EN    = DEF_PARITY_EN,
    parameter int PARITY_ODD   = DEF_PARITY_ODD
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int IW = $clog2(DATA_BITS + 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    uart_tx_serializer_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (state_q == ST_IDLE),
        .bit_end_o(bit_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_START;
                    shift_d = data_i;
                    par_d   = parity_of(32'(data_i), PARITY_ODD != 0);
                    idx_d   = '0;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // tx is derived from the next state so it changes on the same edge as the FSM.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: even-parity, odd-parity and no-parity instances,
// four clocks per bit, sampled on the falling edge.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_s = '0;
    logic [7:0] data_s [3];
    logic [2:0] tx_s, busy_s, done_s;

    int n_checks = 0;
    int n_fail = 0;

    logic tx_log   [128];
    logic busy_log [128];
    logic done_log [128];

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[0]), .data_i(data_s[0]),
        .tx_o(tx_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]));

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[1]), .data_i(data_s[1]),
        .tx_o(tx_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]));

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[2]), .data_i(data_s[2]),
        .tx_o(tx_s[2]), .busy_o(busy_s[2]), .done_o(done_s[2]));

    // Reference line level for sample i of a frame (sample 0 = first cycle after acceptance).
    function automatic logic exp_tx(input logic [7:0] d, input logic pen,
                                    input logic podd, input int i);
        int b;
        b = i / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pen && b == 9) return (^d) ^ podd;
        return 1'b1;
    endfunction

    // Send on instance sel and log n falling-edge samples. Optional extras:
    // a one-cycle start pulse with new data at pulse_at, start held through hold_until,
    // and a one-cycle reset at rst_at.
    task automatic run_frame(input int sel, input logic [7:0] d, input int n,
                             input int pulse_at, input logic [7:0] pdata,
                             input int hold_until, input int rst_at);
        @(negedge clk);
        data_s[sel] = d;
        start_s[sel] = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_log[i]   = tx_s[sel];
            busy_log[i] = busy_s[sel];
            done_log[i] = done_s[sel];
            start_s[sel] = (i <= hold_until) || (i == pulse_at);
            if (i == pulse_at) data_s[sel] = pdata;
            rst_n = (i != rst_at);
        end
        start_s[sel] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_s = '0;
        for (int k = 0; k < 3; k++) data_s[k] = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_s, busy_s, done_s} !== 9'b111_000_000) begin
            n_fail++;
            $display("FAIL reset_state got tx=%b busy=%b done=%b want 111/000/000",
                     tx_s, busy_s, done_s);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_s, busy_s, done_s} !== 9'b111_000_000) begin
                n_fail++;
                $display("FAIL idle_cycle%0d got tx=%b busy=%b done=%b want 111/000/000",
                         c, tx_s, busy_s, done_s);
            end
        end
    endtask

    task automatic test_even_a5;
        int dcount;
        run_frame(0, 8'hA5, 60, -1, 8'h00, -1, -1);
        for (int i = 0; i < 44; i++) begin
            n_checks++;
            if (tx_log[i] !== exp_tx(8'hA5, 1'b1, 1'b0, i) || busy_log[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL even_a5_s%0d got tx=%b busy=%b want tx=%b busy=1",
                         i, tx_log[i], busy_log[i], exp_tx(8'hA5, 1'b1, 1'b0, i));
            end
        end
        n_checks++;
        if (tx_log[36] !== 1'b0) begin
            n_fail++;
            $display("FAIL even_a5_parity got %b want 0", tx_log[36]);
        end
        n_checks++;
        if ({tx_log[44], busy_log[44], done_log[44], done_log[45]} !== 4'b1010) begin
            n_fail++;
            $display("FAIL even_a5_end got tx=%b busy=%b done=%b,%b want 1 0 1,0",
                     tx_log[44], busy_log[44], done_log[44], done_log[45]);
        end
        dcount = 0;
        for (int i = 0; i < 60; i++) dcount += int'(done_log[i]);
        n_checks++;
        if (dcount != 1) begin
            n_fail++;
            $display("FAIL even_a5_done_count got %0d want 1", dcount);
        end
    endtask

    task automatic test_parity_modes;
        run_frame(1, 8'h00, 50, -1, 8'h00, -1, -1);
        n_checks++;
        if (tx_log[37] !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_00_parity got %b want 1", tx_log[37]);
        end
        n_checks++;
        if (busy_log[43] !== 1'b1 || busy_log[44] !== 1'b0 || done_log[44] !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_00_len got busy43=%b busy44=%b done44=%b want 1 0 1",
                     busy_log[43], busy_log[44], done_log[44]);
        end
        run_frame(2, 8'hFF, 50, -1, 8'h00, -1, -1);
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (tx_log[i] !== exp_tx(8'hFF, 1'b0, 1'b0, i) || busy_log[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL nopar_ff_s%0d got tx=%b busy=%b want tx=%b busy=1",
                         i, tx_log[i], busy_log[i], exp_tx(8'hFF, 1'b0, 1'b0, i));
            end
        end
        n_checks++;
        if (busy_log[40] !== 1'b0 || done_log[40] !== 1'b1 || tx_log[40] !== 1'b1) begin
            n_fail++;
            $display("FAIL nopar_ff_end got busy=%b done=%b tx=%b want 0 1 1",
                     busy_log[40], done_log[40], tx_log[40]);
        end
    endtask

    task automatic test_ignore_busy_start;
        int dcount;
        run_frame(0, 8'h96, 60, 10, 8'h3C, -1, -1);
        for (int i = 0; i < 44; i++) begin
            n_checks++;
            if (tx_log[i] !== exp_tx(8'h96, 1'b1, 1'b0, i)) begin
                n_fail++;
                $display("FAIL ignore_s%0d got tx=%b want %b",
                         i, tx_log[i], exp_tx(8'h96, 1'b1, 1'b0, i));
            end
        end
        dcount = 0;
        for (int i = 0; i < 60; i++) dcount += int'(done_log[i]);
        n_checks++;
        if (dcount != 1 || done_log[44] !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_done got count=%0d done44=%b want 1 1", dcount, done_log[44]);
        end
    endtask

    task automatic test_back_to_back;
        run_frame(0, 8'h55, 100, 0, 8'hAA, 44, -1);
        for (int i = 0; i < 44; i++) begin
            n_checks++;
            if (tx_log[i] !== exp_tx(8'h55, 1'b1, 1'b0, i)) begin
                n_fail++;
                $display("FAIL b2b_first_s%0d got tx=%b want %b",
                         i, tx_log[i], exp_tx(8'h55, 1'b1, 1'b0, i));
            end
        end
        n_checks++;
        if ({tx_log[44], busy_log[44], done_log[44]} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_done_cycle got tx=%b busy=%b done=%b want 1 0 1",
                     tx_log[44], busy_log[44], done_log[44]);
        end
        for (int i = 45; i < 89; i++) begin
            n_checks++;
            if (tx_log[i] !== exp_tx(8'hAA, 1'b1, 1'b0, i - 45) || busy_log[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_second_s%0d got tx=%b busy=%b want tx=%b busy=1",
                         i, tx_log[i], busy_log[i], exp_tx(8'hAA, 1'b1, 1'b0, i - 45));
            end
        end
        n_checks++;
        if (done_log[89] !== 1'b1 || busy_log[89] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_end got done=%b busy=%b want 1 0",
                     done_log[89], busy_log[89]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int dcount;
        run_frame(0, 8'hF0, 60, -1, 8'h00, -1, 17);
        n_checks++;
        if (tx_log[17] !== exp_tx(8'hF0, 1'b1, 1'b0, 17) || busy_log[17] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_before got tx=%b busy=%b want %b 1",
                     tx_log[17], busy_log[17], exp_tx(8'hF0, 1'b1, 1'b0, 17));
        end
        n_checks++;
        if ({tx_log[18], busy_log[18]} !== 2'b10) begin
            n_fail++;
            $display("FAIL rstmid_after got tx=%b busy=%b want 1 0", tx_log[18], busy_log[18]);
        end
        dcount = 0;
        for (int i = 0; i < 60; i++) dcount += int'(done_log[i]);
        n_checks++;
        if (dcount != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done got %0d pulses want 0", dcount);
        end
        run_frame(0, 8'hC3, 50, -1, 8'h00, -1, -1);
        for (int i = 0; i < 45; i++) begin
            n_checks++;
            if (tx_log[i] !== exp_tx(8'hC3, 1'b1, 1'b0, i) || done_log[i] !== (i == 44)) begin
                n_fail++;
                $display("FAIL rstmid_clean_s%0d got tx=%b done=%b want tx=%b done=%b",
                         i, tx_log[i], done_log[i], exp_tx(8'hC3, 1'b1, 1'b0, i), (i == 44));
            end
        end
    endtask

    initial begin
        test_reset();
        test_even_a5();
        test_parity_modes();
        test_ignore_busy_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
